// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and converter state type for the seven-segment scan driver
package ssd_pkg;

  localparam int unsigned SSD_DIGITS    = 4;
  localparam logic [3:0]  SSD_BLANK     = 4'hF;
  localparam int unsigned SSD_MAX_VALUE = 9999;
  localparam int unsigned SSD_BIN_W     = 14;
  localparam int unsigned SSD_BCD_W     = 4 * SSD_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } ssd_state_t;

endpackage

// File: rtl/ssd_bin2bcd.sv
// rtl/ssd_bin2bcd.sv - iterative double-dabble converter, one shift per clock, saturating at 9999
module ssd_bin2bcd
  import ssd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [SSD_BIN_W-1:0] i_bin,
  output logic                 o_busy,
  output logic                 o_commit,
  output logic [SSD_BCD_W-1:0] o_bcd
);

  localparam int unsigned SH_W = SSD_BCD_W + SSD_BIN_W;

  ssd_state_t          r_state;
  ssd_state_t          w_state_nxt;
  logic [3:0]          r_cnt;
  logic [SH_W-1:0]     r_shift;
  logic [SH_W-1:0]     w_adj;
  logic [SSD_BIN_W-1:0] w_sat;

  assign w_sat = (i_bin > SSD_BIN_W'(SSD_MAX_VALUE)) ? SSD_BIN_W'(SSD_MAX_VALUE) : i_bin;

  // Add-3 correction on every BCD nibble before the shift
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < int'(SSD_DIGITS); i++) begin
      if (r_shift[SSD_BIN_W + 4*i +: 4] >= 4'd5)
        w_adj[SSD_BIN_W + 4*i +: 4] = r_shift[SSD_BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_load) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == 4'(SSD_BIN_W - 1)) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && i_load) begin
        r_shift <= {{SSD_BCD_W{1'b0}}, w_sat};
        r_cnt   <= 4'd0;
      end else if (r_state == ST_SHIFT) begin
        r_shift <= w_adj << 1;
        r_cnt   <= r_cnt + 4'd1;
      end
    end
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_commit = (r_state == ST_COMMIT);
  assign o_bcd    = r_shift[SH_W-1 -: SSD_BCD_W];

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - digit scan divider plus BCD conversion front end; SSD_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SSD_BIN_W-1:0] bin_in,
  input  logic                 load,
  output logic                 busy,
  output logic                 done,
  output logic [SSD_BCD_W-1:0] nums,
  output logic [1:0]           ssd_ctl_en
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0]     r_div;
  logic [1:0]           r_ctl;
  logic [SSD_BCD_W-1:0] r_nums;
  logic                 r_done;
  logic                 w_busy;
  logic                 w_commit;
  logic [SSD_BCD_W-1:0] w_bcd;
  logic [SSD_BCD_W-1:0] w_nums_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_ctl <= 2'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_ctl <= r_ctl + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  ssd_bin2bcd u_bin2bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (load),
    .i_bin    (bin_in),
    .o_busy   (w_busy),
    .o_commit (w_commit),
    .o_bcd    (w_bcd)
  );

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // Blank zeros above the highest nonzero digit; digit0 always shows
  function automatic logic [SSD_BCD_W-1:0] blank_leading(input logic [SSD_BCD_W-1:0] v);
    logic lead;
    lead = 1'b1;
    blank_leading = v;
    for (int i = int'(SSD_DIGITS) - 1; i >= 1; i--) begin
      if (lead && v[4*i +: 4] == 4'd0) blank_leading[4*i +: 4] = SSD_BLANK;
      else lead = 1'b0;
    end
  endfunction
  assign w_nums_nxt = blank_leading(w_bcd);
`else
  assign w_nums_nxt = w_bcd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nums <= {SSD_DIGITS{SSD_BLANK}};
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_commit) r_nums <= w_nums_nxt;
    end
  end

  assign busy       = w_busy;
  assign done       = r_done;
  assign nums       = r_nums;
  assign ssd_ctl_en = r_ctl;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [13:0] bin_in;
  logic        load;
  logic        busy;
  logic        done;
  logic [15:0] nums;
  logic [1:0]  ssd_ctl_en;

  int checks;
  int errors;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic [15:0] EXP_42 = 16'hFF42;
  localparam logic [15:0] EXP_0  = 16'hFFF0;
  localparam logic [15:0] EXP_5  = 16'hFFF5;
  localparam logic [15:0] EXP_7  = 16'hFFF7;
`else
  localparam logic [15:0] EXP_42 = 16'h0042;
  localparam logic [15:0] EXP_0  = 16'h0000;
  localparam logic [15:0] EXP_5  = 16'h0005;
  localparam logic [15:0] EXP_7  = 16'h0007;
`endif

  ssd_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bin_in     (bin_in),
    .load       (load),
    .busy       (busy),
    .done       (done),
    .nums       (nums),
    .ssd_ctl_en (ssd_ctl_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (nums !== 16'hFFFF) begin errors++; $display("FAIL reset_nums got %h want ffff", nums); end
    checks++; if (ssd_ctl_en !== 2'd0) begin errors++; $display("FAIL reset_ctl got %0d want 0", ssd_ctl_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_scan();
    logic [1:0] exp_ctl;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      exp_ctl = 2'((k / 4) % 4);
      checks++;
      if (ssd_ctl_en !== exp_ctl) begin
        errors++; $display("FAIL scan_ctl k=%0d got %0d want %0d", k, ssd_ctl_en, exp_ctl);
      end
    end
    checks++; if (nums !== 16'hFFFF) begin errors++; $display("FAIL scan_nums got %h want ffff", nums); end
  endtask

  // Caller is at a negedge; load is presented for exactly one rising edge
  task automatic test_convert(input logic [13:0] val, input logic [15:0] exp_nums, input string name);
    int done_k, done_cnt, busy_cnt;
    done_k = 0; done_cnt = 0; busy_cnt = 0;
    bin_in = val; load = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) load = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
    end
    checks++; if (done_k != 16) begin errors++; $display("FAIL %s done_time got %0d want 16", name, done_k); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt); end
    checks++; if (busy_cnt != 15) begin errors++; $display("FAIL %s busy_cycles got %0d want 15", name, busy_cnt); end
    checks++; if (nums !== exp_nums) begin errors++; $display("FAIL %s nums got %h want %h", name, nums, exp_nums); end
  endtask

  task automatic test_back_to_back();
    int done_k;
    int waited;
    done_k = 0;
    bin_in = 14'd5; load = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bin_in = 14'd7;
      if (done === 1'b1 && done_k == 0) begin
        done_k = k;
        checks++; if (nums !== EXP_5) begin errors++; $display("FAIL b2b_first_nums got %h want %h", nums, EXP_5); end
      end
      if (k == 16) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_commit_gap busy got %b want 0", busy); end
      end
      if (k == 17) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_start busy got %b want 1", busy); end
      end
    end
    load = 1'b0;
    checks++; if (done_k != 16) begin errors++; $display("FAIL b2b_first_done got %0d want 16", done_k); end
    waited = 0;
    while (done !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done timeout got %b want 1", done); end
    checks++; if (nums !== EXP_7) begin errors++; $display("FAIL b2b_second_nums got %h want %h", nums, EXP_7); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    done_cnt = 0;
    bin_in = 14'd8888; load = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) load = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (nums !== 16'hFFFF) begin errors++; $display("FAIL abort_nums got %h want ffff", nums); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", done_cnt); end
    rst_n = 1'b1;
    checks++; if (nums !== 16'hFFFF) begin errors++; $display("FAIL abort_release_nums got %h want ffff", nums); end
    test_convert(14'd1234, 16'h1234, "first_after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan();
    test_convert(14'd1234, 16'h1234, "conv_1234");
    test_convert(14'd12000, 16'h9999, "conv_sat");
    test_convert(14'd42, EXP_42, "conv_42");
    test_convert(14'd0, EXP_0, "conv_0");
    test_convert(14'd9999, 16'h9999, "conv_9999");
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
